// File: rtl/ibex_rf_ctx_pkg.sv
// Shared types and constants for the register-file context save/restore sequencer.
// The effective-mask helper keeps the RV32E clip and the x0 exclusion in one place.
package ibex_rf_ctx_pkg;

    typedef enum logic [2:0] {
        CTX_IDLE     = 3'd0,
        CTX_SAVE_RD  = 3'd1,
        CTX_SAVE_OUT = 3'd2,
        CTX_RESTORE  = 3'd3,
        CTX_DONE     = 3'd4
    } ctx_state_e;

    localparam logic [31:0] DefaultSaveMask = 32'hF003_FCE2;
    localparam logic [31:0] RV32EMaskClip   = 32'h0000_FFFF;

    // x0 is hardwired, so bit 0 never takes part in a sequence.
    function automatic logic [31:0] ctx_eff_mask(input logic rv32e, input logic [31:0] mask);
        logic [31:0] m;
        m = rv32e ? (mask & RV32EMaskClip) : mask;
        return m & 32'hFFFF_FFFE;
    endfunction

endpackage

// File: rtl/ibex_rf_ctx_next_idx.sv
// Priority encoder picking the next register to visit: lowest set bit when
// ascending (save), highest set bit when descending (restore).
module ibex_rf_ctx_next_idx (
    input  logic [31:0] i_mask,
    input  logic        i_descending,
    output logic [4:0]  o_idx,
    output logic        o_none
);

    always_comb begin
        o_idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (i_descending) begin
                if (i_mask[i]) o_idx = 5'(i);
            end else begin
                if (i_mask[31 - i]) o_idx = 5'(31 - i);
            end
        end
    end

    assign o_none = (i_mask == 32'd0);

endmodule

// File: rtl/ibex_rf_ctx_sequencer.sv
// Context save/restore sequencer between the core and regfile write port / read port A.
// Saves masked registers ascending over a valid/ready stream, restores them descending.
//
// state        | meaning
// -------------+------------------------------------------------------------
// CTX_IDLE     | regfile ports mirror the core; waiting for save/restore request
// CTX_SAVE_RD  | read register r_idx, capture word and index for the stream
// CTX_SAVE_OUT | st_valid_o held until st_ready_i, then advance to next index
// CTX_RESTORE  | ld_ready_o high; each accepted word is written to r_idx
// CTX_DONE     | one-cycle done_o pulse, then back to idle
module ibex_rf_ctx_sequencer
    import ibex_rf_ctx_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter logic [31:0] SaveMask  = DefaultSaveMask
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 save_req_i,
    input  logic                 restore_req_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,

    input  logic [4:0]           core_raddr_a_i,
    output logic [DataWidth-1:0] core_rdata_a_o,
    input  logic [4:0]           core_waddr_i,
    input  logic [DataWidth-1:0] core_wdata_i,
    input  logic                 core_we_i,

    output logic [4:0]           rf_raddr_a_o,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    output logic [4:0]           rf_waddr_a_o,
    output logic [DataWidth-1:0] rf_wdata_a_o,
    output logic                 rf_we_a_o,

    output logic                 st_valid_o,
    input  logic                 st_ready_i,
    output logic [DataWidth-1:0] st_data_o,
    output logic [4:0]           st_idx_o,

    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [DataWidth-1:0] ld_data_i
);

    localparam logic [31:0] EffMask = ctx_eff_mask(RV32E, SaveMask);

    ctx_state_e           r_state;
    ctx_state_e           w_state_nxt;
    logic [4:0]           r_idx;
    logic [31:0]          r_visited;
    logic [DataWidth-1:0] r_st_data;
    logic [4:0]           r_st_idx;
    logic                 r_err;

    logic                 w_idle;
    logic                 w_save_hs;
    logic                 w_ld_hs;
    logic [31:0]          w_cur_onehot;
    logic [31:0]          w_enc_mask;
    logic                 w_enc_desc;
    logic [4:0]           w_next_idx;
    logic                 w_none;

    assign w_idle       = (r_state == CTX_IDLE);
    assign w_save_hs    = (r_state == CTX_SAVE_OUT) && st_ready_i;
    assign w_ld_hs      = (r_state == CTX_RESTORE) && ld_valid_i;
    assign w_cur_onehot = 32'd1 << r_idx;

    // In idle the encoder finds the first index of the requested sequence;
    // afterwards it looks past the current index for the one after it.
    always_comb begin
        w_enc_mask = EffMask;
        w_enc_desc = !save_req_i;
        if (!w_idle) begin
            w_enc_mask = EffMask & ~r_visited & ~w_cur_onehot;
            w_enc_desc = (r_state == CTX_RESTORE);
        end
    end

    ibex_rf_ctx_next_idx u_next_idx (
        .i_mask       (w_enc_mask),
        .i_descending (w_enc_desc),
        .o_idx        (w_next_idx),
        .o_none       (w_none)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CTX_IDLE: begin
                if (save_req_i) begin
                    w_state_nxt = w_none ? CTX_DONE : CTX_SAVE_RD;
                end else if (restore_req_i) begin
                    w_state_nxt = w_none ? CTX_DONE : CTX_RESTORE;
                end
            end
            CTX_SAVE_RD:  w_state_nxt = CTX_SAVE_OUT;
            CTX_SAVE_OUT: if (w_save_hs) w_state_nxt = w_none ? CTX_DONE : CTX_SAVE_RD;
            CTX_RESTORE:  if (w_ld_hs)   w_state_nxt = w_none ? CTX_DONE : CTX_RESTORE;
            CTX_DONE:     w_state_nxt = CTX_IDLE;
            default:      w_state_nxt = CTX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= CTX_IDLE;
            r_idx     <= 5'd0;
            r_visited <= 32'd0;
            r_st_data <= '0;
            r_st_idx  <= 5'd0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= !w_idle && core_we_i;
            if (w_idle) begin
                r_visited <= 32'd0;
                if (save_req_i || restore_req_i) r_idx <= w_next_idx;
            end
            if (r_state == CTX_SAVE_RD) begin
                r_st_data <= rf_rdata_a_i;
                r_st_idx  <= r_idx;
            end
            if (w_save_hs || w_ld_hs) begin
                r_visited <= r_visited | w_cur_onehot;
                r_idx     <= w_next_idx;
            end
        end
    end

    assign busy_o         = !w_idle;
    assign done_o         = (r_state == CTX_DONE);
    assign err_o          = r_err;
    assign core_rdata_a_o = rf_rdata_a_i;

    // Reset blocks any beat or write in the cycle it is asserted, so an
    // aborted sequence never leaves a partially committed extra word.
    assign st_valid_o   = (r_state == CTX_SAVE_OUT) && !rst_i;
    assign ld_ready_o   = (r_state == CTX_RESTORE) && !rst_i;
    assign st_data_o    = r_st_data;
    assign st_idx_o     = r_st_idx;

    assign rf_raddr_a_o = w_idle ? core_raddr_a_i : r_idx;
    assign rf_waddr_a_o = w_idle ? core_waddr_i   : r_idx;
    assign rf_wdata_a_o = w_idle ? core_wdata_i   : ld_data_i;
    assign rf_we_a_o    = !rst_i && (w_idle ? core_we_i : w_ld_hs);

endmodule

// File: tb/tb_ibex_rf_ctx_sequencer.sv
// Scoreboard bench for ibex_rf_ctx_sequencer: a regfile array, a golden register
// image, expected stream/write queues and a negedge monitor that pops and compares.
module tb_ibex_rf_ctx_sequencer;

    localparam int DW = 32;
    localparam logic [31:0] DEF_MASK = 32'hF003_FCE2;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_i, save_req_i, restore_req_i, core_we_i, st_ready_i, ld_valid_i;
    logic [4:0]    core_raddr_a_i, core_waddr_i;
    logic [DW-1:0] core_wdata_i, ld_data_i;
    logic          busy_o, done_o, err_o, rf_we_a_o, st_valid_o, ld_ready_o;
    logic [4:0]    rf_raddr_a_o, rf_waddr_a_o, st_idx_o;
    logic [DW-1:0] core_rdata_a_o, rf_rdata_a_i, rf_wdata_a_o, st_data_o;

    ibex_rf_ctx_sequencer u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .save_req_i(save_req_i), .restore_req_i(restore_req_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .core_raddr_a_i(core_raddr_a_i), .core_rdata_a_o(core_rdata_a_o),
        .core_waddr_i(core_waddr_i), .core_wdata_i(core_wdata_i), .core_we_i(core_we_i),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_rdata_a_i(rf_rdata_a_i),
        .rf_waddr_a_o(rf_waddr_a_o), .rf_wdata_a_o(rf_wdata_a_o), .rf_we_a_o(rf_we_a_o),
        .st_valid_o(st_valid_o), .st_ready_i(st_ready_i), .st_data_o(st_data_o), .st_idx_o(st_idx_o),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_data_i(ld_data_i)
    );

    // Secondary instances: RV32E clip and an empty mask, fed a fixed read pattern.
    logic          save_req_x;
    logic          one_b = 1'b1, zero_b = 1'b0;
    logic [4:0]    zero5 = 5'd0;
    logic [DW-1:0] zero_w = '0;
    logic          busy_e, done_e, err_e, we_e, stv_e, ldr_e;
    logic [4:0]    ra_e, wa_e, idx_e;
    logic [DW-1:0] crd_e, rd_e, wd_e, sd_e;
    logic          busy_z, done_z, err_z, we_z, stv_z, ldr_z;
    logic [4:0]    ra_z, wa_z, idx_z;
    logic [DW-1:0] crd_z, rd_z, wd_z, sd_z;
    assign rd_e = 32'hA000 + 32'(ra_e);
    assign rd_z = 32'hB000 + 32'(ra_z);

    ibex_rf_ctx_sequencer #(.RV32E(1'b1)) u_dut_e (
        .clk_i(clk_i), .rst_i(rst_i), .save_req_i(save_req_x), .restore_req_i(zero_b),
        .busy_o(busy_e), .done_o(done_e), .err_o(err_e),
        .core_raddr_a_i(zero5), .core_rdata_a_o(crd_e), .core_waddr_i(zero5),
        .core_wdata_i(zero_w), .core_we_i(zero_b),
        .rf_raddr_a_o(ra_e), .rf_rdata_a_i(rd_e), .rf_waddr_a_o(wa_e), .rf_wdata_a_o(wd_e),
        .rf_we_a_o(we_e), .st_valid_o(stv_e), .st_ready_i(one_b), .st_data_o(sd_e),
        .st_idx_o(idx_e), .ld_valid_i(zero_b), .ld_ready_o(ldr_e), .ld_data_i(zero_w)
    );

    ibex_rf_ctx_sequencer #(.SaveMask(32'd0)) u_dut_z (
        .clk_i(clk_i), .rst_i(rst_i), .save_req_i(save_req_x), .restore_req_i(zero_b),
        .busy_o(busy_z), .done_o(done_z), .err_o(err_z),
        .core_raddr_a_i(zero5), .core_rdata_a_o(crd_z), .core_waddr_i(zero5),
        .core_wdata_i(zero_w), .core_we_i(zero_b),
        .rf_raddr_a_o(ra_z), .rf_rdata_a_i(rd_z), .rf_waddr_a_o(wa_z), .rf_wdata_a_o(wd_z),
        .rf_we_a_o(we_z), .st_valid_o(stv_z), .st_ready_i(one_b), .st_data_o(sd_z),
        .st_idx_o(idx_z), .ld_valid_i(zero_b), .ld_ready_o(ldr_z), .ld_data_i(zero_w)
    );

    // Regfile behind the main instance.
    logic [DW-1:0] rf [32];
    assign rf_rdata_a_i = (rf_raddr_a_o == 5'd0) ? '0 : rf[rf_raddr_a_o];
    always @(posedge clk_i) if (rf_we_a_o && rf_waddr_a_o != 5'd0) rf[rf_waddr_a_o] <= rf_wdata_a_o;

    typedef struct packed {
        logic [4:0]    idx;
        logic [DW-1:0] data;
    } beat_t;

    logic [DW-1:0] gold [32];
    logic [DW-1:0] ld_vals [32];
    beat_t         exp_st [$];
    beat_t         exp_wr [$];
    int            order [$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            seq_c0 = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_mask(input bit rv32e, input logic [31:0] m);
        logic [31:0] r;
        r = rv32e ? (m & 32'h0000_FFFF) : m;
        r[0] = 1'b0;
        return r;
    endfunction

    task automatic make_order(input logic [31:0] mask, input bit desc);
        order.delete();
        if (desc) begin
            for (int i = 31; i >= 1; i--) if (mask[i]) order.push_back(i);
        end else begin
            for (int i = 1; i < 32; i++) if (mask[i]) order.push_back(i);
        end
    endtask

    // Monitor: pops expectations on every stream beat and sequencer-driven write.
    logic          stall_prev = 1'b0;
    logic [4:0]    stall_idx;
    logic [DW-1:0] stall_data;
    always @(negedge clk_i) begin
        beat_t e;
        if (st_valid_o && st_ready_i) begin
            if (exp_st.size() == 0) begin
                checks++; errors++;
                $display("FAIL st_extra_beat: idx %0d data %0h, expected no beat", st_idx_o, st_data_o);
            end else begin
                e = exp_st.pop_front();
                chk("st_idx", 64'(st_idx_o), 64'(e.idx));
                chk("st_data", 64'(st_data_o), 64'(e.data));
            end
        end
        if (stall_prev && st_valid_o) begin
            chk("stall_idx", 64'(st_idx_o), 64'(stall_idx));
            chk("stall_data", 64'(st_data_o), 64'(stall_data));
        end
        stall_prev = st_valid_o && !st_ready_i;
        stall_idx  = st_idx_o;
        stall_data = st_data_o;
        if (busy_o && rf_we_a_o) begin
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL rf_extra_write: addr %0d data %0h, expected no write", rf_waddr_a_o, rf_wdata_a_o);
            end else begin
                e = exp_wr.pop_front();
                chk("rf_waddr", 64'(rf_waddr_a_o), 64'(e.idx));
                chk("rf_wdata", 64'(rf_wdata_a_o), 64'(e.data));
            end
        end
    end

    task automatic check_regs(input string name);
        for (int i = 1; i < 32; i++) begin
            core_raddr_a_i = 5'(i);
            #1;
            chk(name, 64'(core_rdata_a_o), 64'(gold[i]));
        end
        @(posedge clk_i); #1;
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the sequence.
    task automatic start_seq(input bit do_save, input bit do_rest, input bit do_we,
                             input logic [4:0] wa, input logic [DW-1:0] wd,
                             input int keep_writes, input bit rand_data);
        if (do_we && wa != 5'd0) gold[wa] = wd;
        if (do_save) begin
            make_order(ref_mask(1'b0, DEF_MASK), 1'b0);
            foreach (order[j]) exp_st.push_back({5'(order[j]), gold[order[j]]});
        end else if (do_rest) begin
            make_order(ref_mask(1'b0, DEF_MASK), 1'b1);
            foreach (order[j]) begin
                ld_vals[j] = rand_data ? DW'($urandom) : DW'(32'h100 + j);
                if (j < keep_writes) begin
                    exp_wr.push_back({5'(order[j]), ld_vals[j]});
                    gold[order[j]] = ld_vals[j];
                end
            end
        end
        save_req_i = do_save; restore_req_i = do_rest;
        core_we_i = do_we; core_waddr_i = wa; core_wdata_i = wd;
        seq_c0 = cyc;
        @(posedge clk_i); #1;
        save_req_i = 1'b0; restore_req_i = 1'b0; core_we_i = 1'b0;
    endtask

    task automatic run_seq(input int rdy_mode, input int ldv_mode, input int exp_lat,
                           input int rst_beat, input bit core_poke);
        int k = 0;
        int n = 1;
        bit fin = 1'b0;
        while (!fin && n < 400) begin
            case (rdy_mode)
                0:       st_ready_i = 1'b1;
                1:       st_ready_i = (n % 3 == 0);
                default: st_ready_i = 1'($urandom_range(0, 1));
            endcase
            ld_valid_i   = (ldv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ld_data_i    = ld_vals[k % 32];
            core_we_i    = core_poke && (n == 4);
            core_waddr_i = 5'd6;
            core_wdata_i = 32'hBAD0_0BAD;
            if (k == rst_beat && ld_ready_o && ld_valid_i) begin
                rst_i = 1'b1;
                @(posedge clk_i); #1;
                rst_i = 1'b0; ld_valid_i = 1'b0;
                chk("reset_outputs", 64'({busy_o, done_o, err_o, st_valid_o, ld_ready_o, rf_we_a_o, st_idx_o, st_data_o}), 64'd0);
                fin = 1'b1;
            end else begin
                @(negedge clk_i);
                if (core_poke && n == 4) chk("err_before_poke", 64'(err_o), 64'd0);
                if (core_poke && n == 5) chk("err_pulse", 64'(err_o), 64'd1);
                if (ld_valid_i && ld_ready_o) k++;
                if (done_o) begin
                    if (exp_lat >= 0) chk("done_cycle", 64'(cyc - seq_c0), 64'(exp_lat));
                    @(posedge clk_i); #1;
                    chk("busy_after_done", 64'(busy_o), 64'd0);
                    fin = 1'b1;
                end else begin
                    @(posedge clk_i); #1;
                    n++;
                end
            end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL seq_timeout: no done_o after %0d cycles, expected done", n);
        end
        st_ready_i = 1'b0; ld_valid_i = 1'b0; core_we_i = 1'b0;
        chk("st_queue_left", 64'(exp_st.size()), 64'd0);
        chk("wr_queue_left", 64'(exp_wr.size()), 64'd0);
        exp_st.delete(); exp_wr.delete();
    endtask

    task automatic run_secondary();
        int cnt_e = 0;
        int cnt_z = 0;
        bit fin = 1'b0;
        make_order(ref_mask(1'b1, DEF_MASK), 1'b0);
        save_req_x = 1'b1;
        @(posedge clk_i); #1;
        save_req_x = 1'b0;
        for (int n = 1; n < 100 && !fin; n++) begin
            @(negedge clk_i);
            if (n == 1) chk("z_done_cycle1", 64'(done_z), 64'd1);
            if (stv_z) cnt_z++;
            if (stv_e) begin
                if (cnt_e < order.size()) begin
                    chk("e_idx", 64'(idx_e), 64'(order[cnt_e]));
                    chk("e_data", 64'(sd_e), 64'(32'hA000 + order[cnt_e]));
                end
                cnt_e++;
            end
            if (done_e) fin = 1'b1;
        end
        chk("e_finished", 64'(fin), 64'd1);
        chk("e_beats", 64'(cnt_e), 64'd10);
        chk("z_beats", 64'(cnt_z), 64'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        rst_i = 1'b1; save_req_i = 1'b0; restore_req_i = 1'b0; save_req_x = 1'b0;
        core_we_i = 1'b0; core_raddr_a_i = 5'd0; core_waddr_i = 5'd0; core_wdata_i = '0;
        st_ready_i = 1'b0; ld_valid_i = 1'b0; ld_data_i = '0;
        for (int i = 0; i < 32; i++) begin gold[i] = '0; ld_vals[i] = '0; end
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_state", 64'({busy_o, done_o, err_o, st_valid_o, ld_ready_o, rf_we_a_o, st_idx_o, st_data_o}), 64'd0);
        chk("reset_state_aux", 64'({busy_e, busy_z, stv_e, stv_z}), 64'd0);
        @(posedge clk_i); #1;

        for (int i = 1; i < 32; i++) begin
            core_we_i = 1'b1; core_waddr_i = 5'(i); core_wdata_i = DW'($urandom);
            gold[i] = core_wdata_i;
            @(posedge clk_i); #1;
        end
        core_we_i = 1'b0;
        check_regs("preload_read");

        start_seq(1'b1, 1'b0, 1'b0, 5'd0, '0, 0, 1'b0);
        run_seq(0, 0, 33, -1, 1'b0);

        start_seq(1'b0, 1'b1, 1'b0, 5'd0, '0, 99, 1'b0);
        run_seq(0, 0, 17, -1, 1'b0);
        check_regs("restore_read");

        start_seq(1'b1, 1'b0, 1'b0, 5'd0, '0, 0, 1'b0);
        run_seq(1, 0, -1, -1, 1'b0);

        start_seq(1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD, 0, 1'b0);
        run_seq(0, 0, 33, -1, 1'b1);
        check_regs("simul_read");

        for (int r = 0; r < 2; r++) begin
            start_seq(1'b0, 1'b1, 1'b0, 5'd0, '0, 99, 1'b1);
            run_seq(0, 1, -1, -1, 1'b0);
            start_seq(1'b1, 1'b0, 1'b0, 5'd0, '0, 0, 1'b0);
            run_seq(2, 0, -1, -1, 1'b0);
        end
        check_regs("random_read");

        start_seq(1'b0, 1'b1, 1'b0, 5'd0, '0, 2, 1'b1);
        run_seq(0, 0, -1, 2, 1'b0);
        check_regs("reset_abort_read");

        start_seq(1'b1, 1'b0, 1'b0, 5'd0, '0, 0, 1'b0);
        run_seq(0, 0, 33, -1, 1'b0);

        run_secondary();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
